// File: rtl/mod_sync_pkg.sv
// Shared widths, FSM states and helpers for the modulation clock sync path.
package mod_sync_pkg;
   localparam int unsigned MOD_IDX_W = 16;
   localparam int unsigned TIME_W    = 64;

   typedef enum logic [1:0] {IDLE, ARMED, RUN} mod_sync_state_t;

   // A divider of zero behaves as one clock per sample.
   function automatic logic [MOD_IDX_W-1:0] div_floor1(input logic [MOD_IDX_W-1:0] d);
      return (d == '0) ? MOD_IDX_W'(1) : d;
   endfunction
endpackage

// File: rtl/mod_sync_if.sv
// Modulation clock settings published by the configuration block.
interface mod_sync_if;
   import mod_sync_pkg::*;

   logic                 MOD_CLK_INIT;
   logic [MOD_IDX_W-1:0] MOD_CLK_CYCLE;
   logic [MOD_IDX_W-1:0] MOD_CLK_DIV;
   logic [TIME_W-1:0]    MOD_CLK_SYNC_TIME_NS;

   modport master_port (output MOD_CLK_INIT, MOD_CLK_CYCLE, MOD_CLK_DIV, MOD_CLK_SYNC_TIME_NS);
   modport slave_port  (input  MOD_CLK_INIT, MOD_CLK_CYCLE, MOD_CLK_DIV, MOD_CLK_SYNC_TIME_NS);
endinterface

// File: rtl/mod_idx_counter.sv
// Divider counter and wrapping sample index; tick marks each index advance.
module mod_idx_counter
   import mod_sync_pkg::*;
(
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 load,
   input  logic                 run,
   input  logic [MOD_IDX_W-1:0] div_l,
   input  logic [MOD_IDX_W-1:0] cycle_l,
   output logic [MOD_IDX_W-1:0] idx,
   output logic                 tick
);
   logic [MOD_IDX_W-1:0] div_cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         div_cnt <= '0;
         idx     <= '0;
         tick    <= 1'b0;
      end else begin
         tick <= 1'b0;
         if (load) begin
            div_cnt <= '0;
            idx     <= '0;
         end else if (run) begin
            if (div_cnt == div_l - MOD_IDX_W'(1)) begin
               div_cnt <= '0;
               idx     <= (idx == cycle_l) ? '0 : idx + MOD_IDX_W'(1);
               tick    <= 1'b1;
            end else begin
               div_cnt <= div_cnt + MOD_IDX_W'(1);
            end
         end
      end
   end
endmodule

// File: rtl/mod_clk_sync.sv
// Consumer of mod_sync_if: arms on an INIT edge, starts at the sync time and
// produces the running modulation sample index.
module mod_clk_sync
   import mod_sync_pkg::*;
#(
   parameter string ENABLE_MODULATION = "TRUE"
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   mod_sync_if.slave_port       MOD_SYNC,
   input  logic [TIME_W-1:0]    SYS_TIME_NS,
   output logic [MOD_IDX_W-1:0] MOD_IDX,
   output logic                 MOD_UPDATE,
   output logic                 MOD_RUNNING
);
   if (ENABLE_MODULATION == "TRUE") begin : g_mod
      mod_sync_state_t      state_q, state_d;
      logic                 init_d;
      logic                 req;
      logic                 start;
      logic                 start_q;
      logic [MOD_IDX_W-1:0] cycle_l;
      logic [MOD_IDX_W-1:0] div_l;
      logic [TIME_W-1:0]    sync_l;
      logic [MOD_IDX_W-1:0] idx;
      logic                 tick;

      assign req = MOD_SYNC.MOD_CLK_INIT & ~init_d;

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            state_q <= IDLE;
            init_d  <= 1'b0;
            start_q <= 1'b0;
            cycle_l <= '0;
            div_l   <= '0;
            sync_l  <= '0;
         end else begin
            state_q <= state_d;
            init_d  <= MOD_SYNC.MOD_CLK_INIT;
            start_q <= start;
            if (req) begin
               cycle_l <= MOD_SYNC.MOD_CLK_CYCLE;
               div_l   <= div_floor1(MOD_SYNC.MOD_CLK_DIV);
               sync_l  <= MOD_SYNC.MOD_CLK_SYNC_TIME_NS;
            end
         end
      end

      // A request overrides any transition, including a start in the same cycle.
      always_comb begin
         state_d = state_q;
         start   = 1'b0;
         case (state_q)
            IDLE:  state_d = IDLE;
            ARMED: begin
               if (SYS_TIME_NS >= sync_l) begin
                  state_d = RUN;
                  start   = 1'b1;
               end
            end
            RUN:     state_d = RUN;
            default: state_d = IDLE;
         endcase
         if (req) begin
            state_d = ARMED;
            start   = 1'b0;
         end
      end

      mod_idx_counter u_idx_counter (
         .CLK     (CLK),
         .RST_N   (RST_N),
         .load    (req | start),
         .run     (state_q == RUN),
         .div_l   (div_l),
         .cycle_l (cycle_l),
         .idx     (idx),
         .tick    (tick)
      );

      // The start pulse and divider ticks never coincide: start also loads the counter.
      assign MOD_IDX     = idx;
      assign MOD_UPDATE  = tick | start_q;
      assign MOD_RUNNING = (state_q == RUN);
   end else begin : g_off
      assign MOD_IDX     = '0;
      assign MOD_UPDATE  = 1'b0;
      assign MOD_RUNNING = 1'b0;
   end
endmodule

// File: tb/tb_mod_clk_sync.sv
// Self-checking bench for mod_clk_sync: vector tables, directed corner cases
// and randomized traffic against an elapsed-time reference model.
module tb_mod_clk_sync;
   import mod_sync_pkg::*;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [63:0] SYS_TIME_NS;
   logic [15:0] MOD_IDX;
   logic        MOD_UPDATE;
   logic        MOD_RUNNING;

   mod_sync_if msif ();

   mod_clk_sync #(.ENABLE_MODULATION("TRUE")) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .MOD_SYNC    (msif),
      .SYS_TIME_NS (SYS_TIME_NS),
      .MOD_IDX     (MOD_IDX),
      .MOD_UPDATE  (MOD_UPDATE),
      .MOD_RUNNING (MOD_RUNNING)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   longint unsigned now_ns;

   // Reference model: index derived from clocks elapsed since the start.
   logic            m_init_d, m_armed, m_run;
   longint unsigned m_cyc, m_div, m_el;
   logic [63:0]     m_sync;
   logic [15:0]     e_idx;
   logic            e_upd, e_run;

   typedef struct {
      logic        init;
      logic [15:0] cyc;
      logic [15:0] div;
      logic [63:0] sync;
      logic [15:0] e_idx;
      logic        e_upd;
      logic        e_run;
   } vec_t;
   vec_t vtab [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_init_d = 1'b0; m_armed = 1'b0; m_run = 1'b0;
      m_cyc = 0; m_div = 1; m_el = 0; m_sync = '0;
      e_idx = '0; e_upd = 1'b0; e_run = 1'b0;
   endtask

   task automatic model_step();
      logic req;
      if (!RST_N) begin
         model_reset();
         return;
      end
      req      = msif.MOD_CLK_INIT && !m_init_d;
      m_init_d = msif.MOD_CLK_INIT;
      e_upd    = 1'b0;
      if (req) begin
         m_cyc   = longint'(msif.MOD_CLK_CYCLE);
         m_div   = (msif.MOD_CLK_DIV == 16'd0) ? 1 : longint'(msif.MOD_CLK_DIV);
         m_sync  = msif.MOD_CLK_SYNC_TIME_NS;
         m_armed = 1'b1;
         m_run   = 1'b0;
         e_idx   = '0;
      end else if (m_armed) begin
         if (SYS_TIME_NS >= m_sync) begin
            m_armed = 1'b0;
            m_run   = 1'b1;
            m_el    = 0;
            e_idx   = '0;
            e_upd   = 1'b1;
         end
      end else if (m_run) begin
         m_el++;
         e_idx = 16'((m_el / m_div) % (m_cyc + 1));
         e_upd = ((m_el % m_div) == 0);
      end
      e_run = m_run;
   endtask

   task automatic tick();
      SYS_TIME_NS = now_ns;
      @(posedge CLK);
      model_step();
      now_ns += 10;
      @(negedge CLK);
      chk("idx", MOD_IDX, e_idx);
      chk("upd", MOD_UPDATE, e_upd);
      chk("run", MOD_RUNNING, e_run);
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      int run_t, n, h, len;
      bit seen;

      // Past sync time: ARMED one cycle, div 2, cycle 1.
      vtab[0]  = '{1'b1, 16'd1, 16'd2, 64'd0, 16'd0, 1'b0, 1'b0};
      vtab[1]  = '{1'b1, 16'd1, 16'd2, 64'd0, 16'd0, 1'b1, 1'b1};
      vtab[2]  = '{1'b0, 16'd1, 16'd2, 64'd0, 16'd0, 1'b0, 1'b1};
      vtab[3]  = '{1'b0, 16'd1, 16'd2, 64'd0, 16'd1, 1'b1, 1'b1};
      vtab[4]  = '{1'b0, 16'd1, 16'd2, 64'd0, 16'd1, 1'b0, 1'b1};
      vtab[5]  = '{1'b0, 16'd1, 16'd2, 64'd0, 16'd0, 1'b1, 1'b1};
      // Zero divider, cycle 2; last row changes config without a request.
      vtab[6]  = '{1'b1, 16'd2, 16'd0, 64'd0, 16'd0, 1'b0, 1'b0};
      vtab[7]  = '{1'b0, 16'd2, 16'd0, 64'd0, 16'd0, 1'b1, 1'b1};
      vtab[8]  = '{1'b0, 16'd2, 16'd0, 64'd0, 16'd1, 1'b1, 1'b1};
      vtab[9]  = '{1'b0, 16'd2, 16'd0, 64'd0, 16'd2, 1'b1, 1'b1};
      vtab[10] = '{1'b0, 16'd2, 16'd0, 64'd0, 16'd0, 1'b1, 1'b1};
      vtab[11] = '{1'b0, 16'd5, 16'd9, 64'd0, 16'd1, 1'b1, 1'b1};

      RST_N = 1'b0;
      msif.MOD_CLK_INIT = 1'b0;
      msif.MOD_CLK_CYCLE = '0;
      msif.MOD_CLK_DIV = '0;
      msif.MOD_CLK_SYNC_TIME_NS = '0;
      now_ns = 0;
      SYS_TIME_NS = '0;
      model_reset();

      @(negedge CLK);
      chk("rst_idx", MOD_IDX, 16'd0);
      chk("rst_upd", MOD_UPDATE, 1'b0);
      chk("rst_run", MOD_RUNNING, 1'b0);
      tick();
      RST_N = 1'b1;
      tick();
      tick();

      // Basic start: cycle 3, div 4, sync 1000, time 10 ns/clk, INIT high 15 clocks.
      now_ns = 0;
      msif.MOD_CLK_CYCLE = 16'd3;
      msif.MOD_CLK_DIV = 16'd4;
      msif.MOD_CLK_SYNC_TIME_NS = 64'd1000;
      seen = 1'b0;
      run_t = -1;
      for (int t = 0; t < 140; t++) begin
         msif.MOD_CLK_INIT = (t < 15);
         tick();
         if (!seen && MOD_RUNNING) begin
            seen = 1'b1;
            run_t = t;
         end
         if (seen && (t - run_t) <= 16) begin
            chk("basic_idx", MOD_IDX, 16'(((t - run_t) / 4) % 4));
            chk("basic_upd", MOD_UPDATE, ((t - run_t) % 4) == 0);
         end
      end
      chk("basic_start_cycle", 64'(run_t), 64'd100);

      // Re-init at index 2 with cycle 7, div 1, sync 100 ns ahead.
      for (int k = 0; k < 20 && MOD_IDX != 16'd2; k++) tick();
      chk("reinit_reach2", MOD_IDX, 16'd2);
      msif.MOD_CLK_CYCLE = 16'd7;
      msif.MOD_CLK_DIV = 16'd1;
      msif.MOD_CLK_SYNC_TIME_NS = now_ns + 100;
      msif.MOD_CLK_INIT = 1'b1;
      tick();
      chk("reinit_idx0", MOD_IDX, 16'd0);
      chk("reinit_noupd", MOD_UPDATE, 1'b0);
      chk("reinit_armed", MOD_RUNNING, 1'b0);
      n = 0;
      for (int k = 0; k < 30 && !MOD_RUNNING; k++) begin
         if (k >= 1) msif.MOD_CLK_INIT = 1'b0;
         tick();
         n++;
      end
      chk("reinit_delay", 64'(n), 64'd10);
      msif.MOD_CLK_INIT = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         if (j == 3) msif.MOD_CLK_DIV = 16'd5;
         tick();
         chk("reinit_wrap7", MOD_IDX, 16'(j % 8));
      end

      // Asynchronous reset in the middle of RUN.
      #2;
      RST_N = 1'b0;
      #1;
      chk("async_rst_idx", MOD_IDX, 16'd0);
      chk("async_rst_upd", MOD_UPDATE, 1'b0);
      chk("async_rst_run", MOD_RUNNING, 1'b0);
      model_reset();
      @(negedge CLK);
      tick();
      RST_N = 1'b1;
      for (int k = 0; k < 5; k++) begin
         msif.MOD_CLK_DIV = 16'($urandom);
         msif.MOD_CLK_SYNC_TIME_NS = 64'd0;
         tick();
      end
      chk("post_rst_idle_run", MOD_RUNNING, 1'b0);
      chk("post_rst_idle_idx", MOD_IDX, 16'd0);

      // Vector tables.
      now_ns += 5000;
      for (int i = 0; i < 12; i++) begin
         msif.MOD_CLK_INIT = vtab[i].init;
         msif.MOD_CLK_CYCLE = vtab[i].cyc;
         msif.MOD_CLK_DIV = vtab[i].div;
         msif.MOD_CLK_SYNC_TIME_NS = vtab[i].sync;
         tick();
         chk("vec_idx", MOD_IDX, vtab[i].e_idx);
         chk("vec_upd", MOD_UPDATE, vtab[i].e_upd);
         chk("vec_run", MOD_RUNNING, vtab[i].e_run);
      end

      // Randomized requests, config noise and occasional resets.
      msif.MOD_CLK_INIT = 1'b0;
      tick();
      for (int seg = 0; seg < 40; seg++) begin
         msif.MOD_CLK_CYCLE = 16'($urandom_range(0, 5));
         msif.MOD_CLK_DIV = 16'($urandom_range(0, 4));
         msif.MOD_CLK_SYNC_TIME_NS = ($urandom_range(0, 3) == 0) ? 64'd0
                                     : now_ns + 64'($urandom_range(0, 300));
         h = int'($urandom_range(1, 3));
         len = int'($urandom_range(h + 2, 50));
         for (int k = 0; k < len; k++) begin
            msif.MOD_CLK_INIT = (k < h);
            if (k >= h && $urandom_range(0, 9) == 0) begin
               msif.MOD_CLK_CYCLE = 16'($urandom);
               msif.MOD_CLK_DIV = 16'($urandom);
               msif.MOD_CLK_SYNC_TIME_NS = {$urandom, $urandom};
            end
            RST_N = ($urandom_range(0, 99) != 0);
            tick();
         end
         RST_N = 1'b1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
